// File: rtl/control_unit_if.sv
// Shared types and the sequencer-to-datapath/imem bundle.
// Combinational bundle: no storage, no latency of its own.
// Backpressure: only imem_ready stalls the sequencer (held in FETCH).
package control_unit_pkg;
  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_operand_a_t;

  typedef enum logic [0:0] {
    ALU_B_RS2 = 1'b0,
    ALU_B_IMM = 1'b1
  } alu_operand_b_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_operation_t;
endpackage

interface control_unit_if;
  import control_unit_pkg::*;

  logic           imem_req;
  logic           imem_ready;
  logic [31:0]    imem_rdata;
  logic           reg_bank_load_en;
  logic [4:0]     reg_bank_sel_in;
  logic [4:0]     reg_bank_sel_out_a;
  logic [4:0]     reg_bank_sel_out_b;
  logic           pc_load_en;
  logic [31:0]    alu_immediate_data;
  alu_operand_a_t alu_operand_a_select;
  alu_operand_b_t alu_operand_b_select;
  alu_operation_t alu_operation;
  logic           halted;
  logic           illegal_instr;
  logic [31:0]    instret;

  // Sequencer side
  modport master (
    output imem_req,
    input  imem_ready, imem_rdata,
    output reg_bank_load_en, reg_bank_sel_in, reg_bank_sel_out_a, reg_bank_sel_out_b,
    output pc_load_en, alu_immediate_data, alu_operand_a_select, alu_operand_b_select,
    output alu_operation, halted, illegal_instr, instret
  );

  // Datapath / instruction memory side
  modport slave (
    input  imem_req,
    output imem_ready, imem_rdata,
    input  reg_bank_load_en, reg_bank_sel_in, reg_bank_sel_out_a, reg_bank_sel_out_b,
    input  pc_load_en, alu_immediate_data, alu_operand_a_select, alu_operand_b_select,
    input  alu_operation, halted, illegal_instr, instret
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle RV32I sequencer (OP, OP-IMM, LUI, AUIPC, JAL): fetch, decode, write-back, PC update.
// Latency: 4 cycles per instruction when imem_ready is high, +1 per FETCH wait cycle.
// Backpressure: stays in FETCH with imem_req high until imem_ready; illegal opcode halts until reset.
module control_unit
  import control_unit_pkg::*;
#(
  parameter logic [31:0] RESET_INSTRET = 32'd0
) (
  input logic clk,
  input logic rst,
  control_unit_if.master bus
);

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_PC_UPDATE,
    S_TRAP
  } state_t;

  state_t      state;
  logic [31:0] ir;
  logic [31:0] instret_q;
  logic        illegal_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] i_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign i_imm  = {{20{ir[31]}}, ir[31:20]};
  assign u_imm  = {ir[31:12], 12'b0};
  assign j_imm  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // funct3 to ALU op; alt selects SUB/SRA where the encoding allows it
  function automatic alu_operation_t funct3_op(input logic [2:0] f3, input logic alt);
    alu_operation_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic           legal;
  alu_operand_a_t exec_a;
  alu_operand_b_t exec_b;
  alu_operation_t exec_op;
  logic [31:0]    exec_imm;

  // Decode IR into legality and the write-back ALU controls
  always_comb begin
    legal    = 1'b0;
    exec_a   = ALU_A_RS1;
    exec_b   = ALU_B_RS2;
    exec_op  = ALU_ADD;
    exec_imm = 32'd0;
    case (opcode)
      OPC_OP: begin
        legal   = (funct7 == 7'h00) ||
                  (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
        exec_op = funct3_op(funct3, ir[30]);
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001)
          legal = (funct7 == 7'h00);
        else if (funct3 == 3'b101)
          legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else
          legal = 1'b1;
        exec_b   = ALU_B_IMM;
        exec_imm = i_imm;
        // ir[30] only means arithmetic shift here; for ADDI it is just an immediate bit
        exec_op  = funct3_op(funct3, ir[30] && (funct3 == 3'b101));
      end
      OPC_LUI: begin
        legal    = 1'b1;
        exec_a   = ALU_A_ZERO;
        exec_b   = ALU_B_IMM;
        exec_imm = u_imm;
      end
      OPC_AUIPC: begin
        legal    = 1'b1;
        exec_a   = ALU_A_PC;
        exec_b   = ALU_B_IMM;
        exec_imm = u_imm;
      end
      OPC_JAL: begin
        legal    = 1'b1;
        exec_a   = ALU_A_PC;
        exec_b   = ALU_B_IMM;
        exec_imm = 32'd4;
      end
      default: legal = 1'b0;
    endcase
  end

  // Sequencer state, instruction register, retired count and trap cause
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ir        <= NOP;
      instret_q <= RESET_INSTRET;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (bus.imem_ready) begin
            ir    <= bus.imem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (legal) begin
            state <= S_EXECUTE;
          end else begin
            state     <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXECUTE: state <= S_PC_UPDATE;
        S_PC_UPDATE: begin
          instret_q <= instret_q + 32'd1;
          state     <= S_FETCH;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath controls as a function of state and IR
  always_comb begin
    bus.imem_req             = 1'b0;
    bus.reg_bank_load_en     = 1'b0;
    bus.reg_bank_sel_in      = 5'd0;
    bus.reg_bank_sel_out_a   = 5'd0;
    bus.reg_bank_sel_out_b   = 5'd0;
    bus.pc_load_en           = 1'b0;
    bus.alu_immediate_data   = 32'd0;
    bus.alu_operand_a_select = ALU_A_RS1;
    bus.alu_operand_b_select = ALU_B_RS2;
    bus.alu_operation        = ALU_ADD;
    case (state)
      S_FETCH: bus.imem_req = 1'b1;
      S_DECODE, S_EXECUTE: begin
        bus.reg_bank_sel_in      = ir[11:7];
        bus.reg_bank_sel_out_a   = ir[19:15];
        bus.reg_bank_sel_out_b   = ir[24:20];
        bus.alu_operand_a_select = exec_a;
        bus.alu_operand_b_select = exec_b;
        bus.alu_operation        = exec_op;
        bus.alu_immediate_data   = exec_imm;
        // x0 is never written; the bank load only fires in EXECUTE
        bus.reg_bank_load_en     = (state == S_EXECUTE) && (ir[11:7] != 5'd0);
      end
      S_PC_UPDATE: begin
        bus.reg_bank_sel_in      = ir[11:7];
        bus.reg_bank_sel_out_a   = ir[19:15];
        bus.reg_bank_sel_out_b   = ir[24:20];
        bus.pc_load_en           = 1'b1;
        bus.alu_operand_a_select = ALU_A_PC;
        bus.alu_operand_b_select = ALU_B_IMM;
        bus.alu_operation        = ALU_ADD;
        bus.alu_immediate_data   = (opcode == OPC_JAL) ? j_imm : 32'd4;
      end
      default: ;
    endcase
  end

  assign bus.halted        = (state == S_TRAP);
  assign bus.illegal_instr = illegal_q;
  assign bus.instret       = instret_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: vector table of legal instructions plus stall, abort and trap sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected write-back controls are queued at fetch and popped when EXECUTE is observed.
module tb_control_unit;
  import control_unit_pkg::*;

  localparam logic [31:0] RST_IR = 32'hFFFF_FFFE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  control_unit_if bus();

  control_unit #(.RESET_INSTRET(RST_IR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [31:0] instr;
    logic        load_en;
    logic [4:0]  sel_in;
    logic [4:0]  sel_a;
    logic [4:0]  sel_b;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [3:0]  op;
    logic        chk_imm;
    logic [31:0] imm;
    logic [31:0] pc_imm;
  } vec_t;

  vec_t        vecs[9];
  vec_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_instret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // The two load enables must never fire together
  always @(negedge clk) begin
    if (rst) chk("enable_exclusive", 32'(bus.reg_bank_load_en & bus.pc_load_en), 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic wait_fetch();
    int k = 0;
    while (!bus.imem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_req", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ready = 1'b0;
    @(negedge clk);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_enables", 32'({bus.reg_bank_load_en, bus.pc_load_en}), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_instr), 32'd0);
    chk("rst_instret", bus.instret, RST_IR);
    rst = 1'b1;
    exp_instret = RST_IR;
    @(negedge clk);
  endtask

  task automatic run_instr(input vec_t v, input int stalls);
    vec_t e;
    wait_fetch();
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.imem_ready = 1'b0;
    for (int i = 0; i < stalls; i++) begin
      chk("stall_req", 32'(bus.imem_req), 32'd1);
      chk("stall_enables", 32'({bus.reg_bank_load_en, bus.pc_load_en}), 32'd0);
      @(negedge clk);
    end
    bus.imem_rdata = v.instr;
    bus.imem_ready = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);  // DECODE
    bus.imem_ready = 1'b0;
    chk("dec_req", 32'(bus.imem_req), 32'd0);
    chk("dec_enables", 32'({bus.reg_bank_load_en, bus.pc_load_en}), 32'd0);
    chk("dec_sel_in", 32'(bus.reg_bank_sel_in), 32'(v.sel_in));
    @(negedge clk);  // EXECUTE
    chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("ex_load_en", 32'(bus.reg_bank_load_en), 32'(e.load_en));
      chk("ex_pc_load_en", 32'(bus.pc_load_en), 32'd0);
      chk("ex_sel_in", 32'(bus.reg_bank_sel_in), 32'(e.sel_in));
      chk("ex_sel_a", 32'(bus.reg_bank_sel_out_a), 32'(e.sel_a));
      chk("ex_sel_b", 32'(bus.reg_bank_sel_out_b), 32'(e.sel_b));
      chk("ex_a_sel", 32'(bus.alu_operand_a_select), 32'(e.a_sel));
      chk("ex_b_sel", 32'(bus.alu_operand_b_select), 32'(e.b_sel));
      chk("ex_op", 32'(bus.alu_operation), 32'(e.op));
      if (e.chk_imm) chk("ex_imm", bus.alu_immediate_data, e.imm);
    end
    @(negedge clk);  // PC_UPDATE
    chk("pc_pc_load_en", 32'(bus.pc_load_en), 32'd1);
    chk("pc_load_en", 32'(bus.reg_bank_load_en), 32'd0);
    chk("pc_a_sel", 32'(bus.alu_operand_a_select), 32'(ALU_A_PC));
    chk("pc_b_sel", 32'(bus.alu_operand_b_select), 32'(ALU_B_IMM));
    chk("pc_op", 32'(bus.alu_operation), 32'(ALU_ADD));
    chk("pc_imm", bus.alu_immediate_data, v.pc_imm);
    chk("pc_instret_hold", bus.instret, exp_instret);
    exp_instret = exp_instret + 32'd1;
    @(negedge clk);  // FETCH
    chk("instret", bus.instret, exp_instret);
    chk("next_fetch_req", 32'(bus.imem_req), 32'd1);
  endtask

  logic [31:0] illegal_words[4];

  initial begin
    // instr        ld  in  a   b   asel bsel op chk imm            pc_imm
    vecs[0] = '{32'h0050_0093, 1, 1, 0, 5, 0, 1, 0, 1, 32'd5,         32'd4};          // addi x1,x0,5
    vecs[1] = '{32'h0100_00EF, 1, 1, 0, 16, 1, 1, 0, 1, 32'd4,        32'd16};         // jal x1,+16
    vecs[2] = '{32'h4020_81B3, 1, 3, 1, 2, 0, 0, 1, 0, 32'd0,         32'd4};          // sub x3,x1,x2
    vecs[3] = '{32'h0000_0013, 0, 0, 0, 0, 0, 1, 0, 1, 32'd0,         32'd4};          // addi x0,x0,0
    vecs[4] = '{32'h4033_5293, 1, 5, 6, 3, 0, 1, 7, 1, 32'h0000_0403, 32'd4};          // srai x5,x6,3
    vecs[5] = '{32'h1234_53B7, 1, 7, 8, 3, 2, 1, 0, 1, 32'h1234_5000, 32'd4};          // lui x7,0x12345
    vecs[6] = '{32'hFFFF_F117, 1, 2, 31, 31, 1, 1, 0, 1, 32'hFFFF_F000, 32'd4};        // auipc x2,0xfffff
    vecs[7] = '{32'hFFDF_F06F, 0, 0, 31, 29, 1, 1, 0, 1, 32'd4,       32'hFFFF_FFFC};  // jal x0,-4
    vecs[8] = '{32'h0020_B233, 1, 4, 1, 2, 0, 0, 4, 0, 32'd0,         32'd4};          // sltu x4,x1,x2

    illegal_words[0] = 32'h0000_0073;  // ecall
    illegal_words[1] = 32'h4020_91B3;  // sll with funct7 0x20
    illegal_words[2] = 32'h4000_9093;  // slli with funct7 0x20
    illegal_words[3] = 32'h0220_8133;  // mul (M extension)

    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'd0;
    exp_instret = RST_IR;

    do_reset();
    // instret starts two below wrap, so the second retirement rolls over to zero
    for (int i = 0; i < 9; i++) run_instr(vecs[i], (i == 2) ? 3 : 0);

    // Abort during EXECUTE: enables drop at once and nothing is retired
    do_reset();
    wait_fetch();
    bus.imem_rdata = vecs[0].instr;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    chk("abort_pre_load_en", 32'(bus.reg_bank_load_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_load_en", 32'(bus.reg_bank_load_en), 32'd0);
    chk("abort_pc_load_en", 32'(bus.pc_load_en), 32'd0);
    chk("abort_req", 32'(bus.imem_req), 32'd0);
    chk("abort_instret", bus.instret, RST_IR);
    @(negedge clk);
    rst = 1'b1;
    exp_instret = RST_IR;
    @(negedge clk);
    chk("abort_refetch", 32'(bus.imem_req), 32'd1);
    run_instr(vecs[2], 0);

    // Illegal instructions trap after DECODE and stay quiet until reset
    for (int w = 0; w < 4; w++) begin
      int quiet_bad;
      do_reset();
      wait_fetch();
      bus.imem_rdata = illegal_words[w];
      bus.imem_ready = 1'b1;
      @(negedge clk);  // DECODE
      bus.imem_ready = 1'b0;
      chk("ill_dec_halted", 32'(bus.halted), 32'd0);
      @(negedge clk);  // TRAP
      chk("ill_halted", 32'(bus.halted), 32'd1);
      chk("ill_flag", 32'(bus.illegal_instr), 32'd1);
      quiet_bad = 0;
      bus.imem_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
        if (bus.imem_req || bus.reg_bank_load_en || bus.pc_load_en || !bus.halted)
          quiet_bad++;
        @(negedge clk);
      end
      bus.imem_ready = 1'b0;
      chk("ill_quiet_cycles", 32'(quiet_bad), 32'd0);
      chk("ill_instret", bus.instret, RST_IR);
      rst = 1'b0;
      #1;
      chk("ill_rst_halted", 32'(bus.halted), 32'd0);
      chk("ill_rst_flag", 32'(bus.illegal_instr), 32'd0);
    end

    do_reset();
    run_instr(vecs[4], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
